// File: rtl/fir_host_seq.sv
// fir_host_seq: host-side sequencer for the FIR core.
// Loads the coefficient memory while in LOAD, then streams buffered samples
// into the core (one per frame) and captures each result into a
// ready/valid output register. Sticky error flags report misuse.
module fir_host_seq #(
  parameter int FRAME_LEN   = 256,
  parameter int NTAPS       = 64,
  parameter int IFIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_waddr,
  input  logic [15:0]              coef_wdata,
  input  logic                     run,
  input  logic [15:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [15:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  input  logic                     err_clr,
  output logic                     err_run,
  output logic                     err_coef,
  output logic                     err_ovf,
  output logic [7:0]               underrun_cnt,
  output logic                     streaming,
  output logic [15:0]              fir_cin,
  output logic [$clog2(NTAPS)-1:0] fir_caddr,
  output logic                     fir_cload,
  output logic [15:0]              fir_din,
  output logic                     fir_valid_in,
  input  logic [15:0]              fir_dout,
  input  logic                     fir_valid
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam int PW  = $clog2(IFIFO_DEPTH);
  localparam int CW  = $clog2(IFIFO_DEPTH + 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  DEPTH_C    = CW'(IFIFO_DEPTH);

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, next_state;

  logic [NTAPS-1:0] mask;
  logic [FCW-1:0]   frame_cnt;
  logic [15:0]      fifo_mem [IFIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fv_q;

  logic run_accept, run_early;
  logic frame_start, fifo_empty, push, pop;
  logic coef_load, coef_stray;
  logic fv_rise, cap_take, cap_drop, underrun;

  // Next state: LOAD leaves only once every coefficient address was written
  always_comb begin
    next_state = state;
    run_accept = 1'b0;
    run_early  = 1'b0;
    case (state)
      LOAD: begin
        if (run) begin
          if (&mask) begin
            next_state = STREAM;
            run_accept = 1'b1;
          end else begin
            run_early = 1'b1;
          end
        end
      end
      STREAM:  next_state = STREAM;
      default: next_state = LOAD;
    endcase
  end

  // Event decode; a frame starts on the edge that makes frame_cnt zero
  always_comb begin
    frame_start = run_accept | ((state == STREAM) && (frame_cnt == FRAME_LAST));
    fifo_empty  = (count == '0);
    push        = s_valid & s_ready;
    pop         = frame_start & ~fifo_empty;
    underrun    = frame_start & fifo_empty;
    coef_load   = (state == LOAD) & coef_we;
    coef_stray  = (state == STREAM) & coef_we;
    fv_rise     = fir_valid & ~fv_q;
    cap_take    = fv_rise & (~m_valid | m_ready);
    cap_drop    = fv_rise & m_valid & ~m_ready;
  end

  assign s_ready   = (count < DEPTH_C);
  assign streaming = (state == STREAM);

  // State register; only reset brings the sequencer back to LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  // Coefficient write path to the core plus the written-address mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_cload <= 1'b0;
      fir_caddr <= '0;
      fir_cin   <= '0;
      mask      <= '0;
    end else begin
      fir_cload <= coef_load;
      if (coef_load) begin
        fir_caddr        <= coef_waddr;
        fir_cin          <= coef_wdata;
        mask[coef_waddr] <= 1'b1;
      end
    end
  end

  // Frame counter: restarts at zero when streaming begins, then free-runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (run_accept) begin
      frame_cnt <= '0;
    end else if (state == STREAM) begin
      frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FCW'(1);
    end
  end

  // Sample FIFO storage; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
  end

  // Sample FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sample issue: fir_din holds its value for the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_din      <= '0;
      fir_valid_in <= 1'b0;
    end else begin
      fir_valid_in <= pop;
      if (pop) fir_din <= fifo_mem[rd_ptr];
    end
  end

  // Result capture on the rising edge of fir_valid into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q    <= 1'b0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      fv_q <= fir_valid;
      if (cap_take) begin
        m_data  <= fir_dout;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Sticky flags and underrun counter; a same-cycle set beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_run      <= 1'b0;
      err_coef     <= 1'b0;
      err_ovf      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (run_early)    err_run <= 1'b1;
      else if (err_clr) err_run <= 1'b0;

      if (coef_stray)   err_coef <= 1'b1;
      else if (err_clr) err_coef <= 1'b0;

      if (cap_drop)     err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;

      if (underrun) begin
        if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end else if (err_clr) begin
        underrun_cnt <= '0;
      end
    end
  end

endmodule
